// File: rtl/line_bank_scheduler_if.sv
// Handshake bundle between the capture writer, imageGenV reader and the line bank scheduler.
// The scheduler uses the slave modport. The master side drives the event pulses.
interface line_bank_scheduler_if #(
  parameter int BANK_W = 2,
  parameter int LINE_W = 8
);
  logic              newFrameIn;
  logic              lineDoneIn;
  logic              nextLine;
  logic              clrErr;
  logic [BANK_W-1:0] wrBank;
  logic              wrEnable;
  logic [BANK_W-1:0] prevBank;
  logic [BANK_W-1:0] curBank;
  logic [BANK_W-1:0] nextBank;
  logic [LINE_W-1:0] curLine;
  logic              sameLine;
  logic              ready;
  logic              overflow;
  logic              underflow;

  modport master (
    output newFrameIn, lineDoneIn, nextLine, clrErr,
    input  wrBank, wrEnable, prevBank, curBank, nextBank, curLine,
           sameLine, ready, overflow, underflow
  );

  modport slave (
    input  newFrameIn, lineDoneIn, nextLine, clrErr,
    output wrBank, wrEnable, prevBank, curBank, nextBank, curLine,
           sameLine, ready, overflow, underflow
  );
endinterface

// File: rtl/line_bank_scheduler.sv
// Ring-of-banks scheduler for the GBA line cache: tracks captured vs displayed lines,
// hands out writer/reader banks and flags writer overruns and reader starvation.
module line_bank_scheduler #(
  parameter int NUM_BANKS = 4,
  parameter int LINES     = 160,
  parameter int BANK_W    = 2,
  parameter int LINE_W    = 8
) (
  input  logic                   pxlClk,
  input  logic                   rst,
  line_bank_scheduler_if.slave   bus
);
  localparam int CW = LINE_W + 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t            state_reg;
  logic [LINE_W-1:0] wr_line_reg;
  logic [LINE_W-1:0] cur_line_reg;
  logic              ready_reg;
  logic              overflow_reg;
  logic              underflow_reg;

  logic [CW-1:0] wr_ext;
  logic [CW-1:0] cur_ext;
  logic [CW-1:0] base_ext;
  logic [CW-1:0] diff_ext;
  logic [CW-1:0] need_ext;
  logic [CW-1:0] next_ext;
  logic          writing;
  logic          wr_enable;
  logic          adv_ok;
  logic          at_last;
  logic          ovf_set;
  logic          und_set;

  // All arithmetic is one bit wider than the counters so LINES itself never wraps.
  always_comb begin
    wr_ext    = {1'b0, wr_line_reg};
    cur_ext   = {1'b0, cur_line_reg};
    base_ext  = (cur_line_reg == '0) ? '0 : cur_ext - CW'(1);
    diff_ext  = wr_ext - base_ext;
    need_ext  = (cur_ext + CW'(3) < CW'(LINES)) ? cur_ext + CW'(3) : CW'(LINES);
    at_last   = (cur_ext == CW'(LINES - 1));
    next_ext  = at_last ? cur_ext : cur_ext + CW'(1);
    writing   = (state_reg == PRIME) || (state_reg == RUN);
    wr_enable = writing && (wr_ext < CW'(LINES)) && (wr_ext >= base_ext)
                && (diff_ext < CW'(NUM_BANKS));
    adv_ok    = (wr_ext >= need_ext);
  end

  // A frame restart discards same-cycle line events, so they can raise no flag.
  always_comb begin
    ovf_set = 1'b0;
    und_set = 1'b0;
    if (!bus.newFrameIn) begin
      ovf_set = bus.lineDoneIn && writing && !wr_enable;
      und_set = bus.nextLine && (state_reg == RUN) && !at_last && !adv_ok;
    end
  end

  always_ff @(posedge pxlClk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      wr_line_reg   <= '0;
      cur_line_reg  <= '0;
      ready_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (bus.newFrameIn) begin
        state_reg    <= PRIME;
        wr_line_reg  <= '0;
        cur_line_reg <= '0;
      end else begin
        if (bus.lineDoneIn && wr_enable) begin
          wr_line_reg <= wr_line_reg + LINE_W'(1);
        end
        case (state_reg)
          IDLE: ;
          PRIME: begin
            if (wr_ext >= CW'(2)) begin
              state_reg <= RUN;
              ready_reg <= 1'b1;
            end
          end
          RUN: begin
            if (bus.nextLine) begin
              if (at_last) begin
                state_reg <= DONE;
              end else if (adv_ok) begin
                cur_line_reg <= cur_line_reg + LINE_W'(1);
              end
            end
          end
          DONE: ;
          default: state_reg <= IDLE;
        endcase
      end
      overflow_reg  <= ovf_set || (overflow_reg && !bus.clrErr);
      underflow_reg <= und_set || (underflow_reg && !bus.clrErr);
    end
  end

  // Bank of line n is n mod NUM_BANKS; edges replicate at lines 0 and LINES-1.
  assign bus.wrBank    = wr_line_reg[BANK_W-1:0];
  assign bus.wrEnable  = wr_enable;
  assign bus.prevBank  = base_ext[BANK_W-1:0];
  assign bus.curBank   = cur_line_reg[BANK_W-1:0];
  assign bus.nextBank  = (state_reg == IDLE) ? '0 : next_ext[BANK_W-1:0];
  assign bus.curLine   = cur_line_reg;
  assign bus.sameLine  = !((state_reg == RUN) && adv_ok);
  assign bus.ready     = ready_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;
endmodule
